// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: the writer always owns a free buffer, and the reader shows the newest completed frame.
// All state is registered on clk_100Mhz. Reset is asynchronous and active-low.
module frame_buffer_scheduler #(
    parameter logic [31:0] BASE_ADDR      = 32'h0100_0000,
    parameter logic [31:0] FRAME_STRIDE   = 32'h0010_0000,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk_100Mhz,
    input  logic             sys_rst_n,
    input  logic             enable,
    input  logic             writer_done,
    input  logic             vsync_sync2,
    output logic [31:0]      w_base_addr,
    output logic [31:0]      r_base_addr,
    output logic             r_valid,
    output logic [1:0]       w_idx,
    output logic [1:0]       r_idx,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] repeat_cnt,
    output logic             stall,
    output logic [1:0]       state
);

    localparam int              TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]     ADDR0   = BASE_ADDR;
    localparam logic [31:0]     ADDR1   = BASE_ADDR + FRAME_STRIDE;
    localparam logic [31:0]     ADDR2   = BASE_ADDR + FRAME_STRIDE + FRAME_STRIDE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        w_idx_q, w_idx_d, r_idx_q, r_idx_d, ready_idx_q, ready_idx_d;
    logic              ready_valid_q, ready_valid_d, r_valid_q, r_valid_d;
    logic [CNT_W-1:0]  drop_q, drop_d, rep_q, rep_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              stall_q, stall_d;
    logic              vs_prev_q, vs_edge;
    logic [31:0]       w_addr_q, r_addr_q;

    function automatic logic [31:0] idx_addr(input logic [1:0] i);
        case (i)
            2'd0:    return ADDR0;
            2'd1:    return ADDR1;
            default: return ADDR2;
        endcase
    endfunction

    // The three indices are always a permutation of 0..2, so the third buffer is 3 - a - b.
    function automatic logic [1:0] third_idx(input logic [1:0] a, input logic [1:0] b);
        return 2'd3 - a - b;
    endfunction

    assign vs_edge = vsync_sync2 & ~vs_prev_q;

    always_comb begin
        state_d       = state_q;
        w_idx_d       = w_idx_q;
        r_idx_d       = r_idx_q;
        ready_idx_d   = ready_idx_q;
        ready_valid_d = ready_valid_q;
        r_valid_d     = r_valid_q;
        drop_d        = drop_q;
        rep_d         = rep_q;
        timer_d       = timer_q;
        stall_d       = stall_q;
        case (state_q)
            S_PRIME, S_RUN: begin
                if (!enable) begin
                    state_d       = S_IDLE;
                    w_idx_d       = 2'd0;
                    r_idx_d       = 2'd2;
                    ready_valid_d = 1'b0;
                    r_valid_d     = 1'b0;
                    timer_d       = '0;
                    stall_d       = 1'b0;
                end else begin
                    if (writer_done) begin
                        timer_d = '0;
                        stall_d = 1'b0;
                    end else if (timer_q != TMR_MAX) begin
                        timer_d = timer_q + 1'b1;
                        if (timer_d == TMR_MAX) stall_d = 1'b1;
                    end
                    if (state_q == S_PRIME) begin
                        if (writer_done) begin
                            ready_idx_d   = w_idx_q;
                            ready_valid_d = 1'b1;
                            w_idx_d       = third_idx(w_idx_q, r_idx_q);
                            state_d       = S_RUN;
                        end
                    end else if (writer_done && vs_edge) begin
                        // Fresh frame goes straight to the reader; any pending ready frame is dropped.
                        r_idx_d       = w_idx_q;
                        w_idx_d       = third_idx(w_idx_q, r_idx_q);
                        ready_valid_d = 1'b0;
                        r_valid_d     = 1'b1;
                        if (ready_valid_q) drop_d = drop_q + 1'b1;
                    end else if (writer_done) begin
                        if (ready_valid_q) drop_d = drop_q + 1'b1;
                        ready_idx_d   = w_idx_q;
                        ready_valid_d = 1'b1;
                        w_idx_d       = third_idx(w_idx_q, r_idx_q);
                    end else if (vs_edge) begin
                        if (ready_valid_q) begin
                            r_idx_d       = ready_idx_q;
                            ready_valid_d = 1'b0;
                            r_valid_d     = 1'b1;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_idx_d       = 2'd0;
                r_idx_d       = 2'd2;
                ready_valid_d = 1'b0;
                r_valid_d     = 1'b0;
                timer_d       = '0;
                stall_d       = 1'b0;
                state_d       = enable ? S_PRIME : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            w_idx_q       <= 2'd0;
            r_idx_q       <= 2'd2;
            ready_idx_q   <= 2'd1;
            ready_valid_q <= 1'b0;
            r_valid_q     <= 1'b0;
            drop_q        <= '0;
            rep_q         <= '0;
            timer_q       <= '0;
            stall_q       <= 1'b0;
            vs_prev_q     <= 1'b0;
            w_addr_q      <= ADDR0;
            r_addr_q      <= ADDR2;
        end else begin
            state_q       <= state_d;
            w_idx_q       <= w_idx_d;
            r_idx_q       <= r_idx_d;
            ready_idx_q   <= ready_idx_d;
            ready_valid_q <= ready_valid_d;
            r_valid_q     <= r_valid_d;
            drop_q        <= drop_d;
            rep_q         <= rep_d;
            timer_q       <= timer_d;
            stall_q       <= stall_d;
            vs_prev_q     <= vsync_sync2;
            w_addr_q      <= idx_addr(w_idx_d);
            r_addr_q      <= idx_addr(r_idx_d);
        end
    end

    // r_valid stays high from the first swap until IDLE: the reader's buffer then holds a complete frame.
    assign w_base_addr = w_addr_q;
    assign r_base_addr = r_addr_q;
    assign r_valid     = r_valid_q;
    assign w_idx       = w_idx_q;
    assign r_idx       = r_idx_q;
    assign drop_cnt    = drop_q;
    assign repeat_cnt  = rep_q;
    assign stall       = stall_q;
    assign state       = state_q;

endmodule

// File: doc/frame_buffer_scheduler.md
# frame_buffer_scheduler

Triple-buffer scheduler for the DDR frame store, replacing single-flag double-buffer swapping between the AXI4 camera writer and the AXI4 HDMI reader. The writer always has a free buffer. The reader always shows the most recently completed frame. Frames are dropped when the camera outruns the display, and repeated when the display outruns the camera. The block sits in the `clk_100Mhz` domain beside the two AXI masters, takes `writer_done` from the writer and the synchronised display vsync, and drives both frame base addresses. It also exposes drop/repeat/stall status for ILA/LED debug.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0100_0000, base address of buffer 0.
- `FRAME_STRIDE`, 32'h0010_0000, byte distance between buffers.
- `TIMEOUT_CYCLES`, 5_000_000, number of `clk_100Mhz` cycles without `writer_done` before `stall` is set (50 ms).
- `CNT_W`, 16, width of the drop/repeat counters.

Ports:
- `clk_100Mhz`  in  1  single clock; every register is on its rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scheduler run enable (level).
- `writer_done`  in  1  one-cycle pulse: writer finished the frame at `w_base_addr`.
- `vsync_sync2`  in  1  display vsync, already synchronised into this domain; multi-cycle high level.
- `w_base_addr`  out  32  frame base address for the writer.
- `r_base_addr`  out  32  frame base address for the reader.
- `r_valid`  out  1  reader buffer holds a completed frame.
- `w_idx`  out  2  buffer index held by the writer (0..2).
- `r_idx`  out  2  buffer index held by the reader (0..2).
- `drop_cnt`  out  CNT_W  count of completed frames overwritten before display; wraps.
- `repeat_cnt`  out  CNT_W  count of vsyncs with no new frame; wraps.
- `stall`  out  1  writer watchdog flag.
- `state`  out  2  FSM state: 0 = IDLE, 1 = PRIME, 2 = RUN.

## Operation
- Internal registers: `w_idx`, `r_idx`, `ready_idx`, `ready_valid`. At all times `w_idx` ≠ `r_idx`. When `ready_valid` = 1, `ready_idx` = 3 − `w_idx` − `r_idx`.
- Address mapping: `addr(i)` = `BASE_ADDR` + i·`FRAME_STRIDE`. Compute it as a 3-way mux of constants, with no multiplier. Both address outputs are registered.
- Vsync event: `vs_edge` = `vsync_sync2` AND NOT `vs_prev`, where `vs_prev` is `vsync_sync2` registered. The level is never used directly.
- FSM:
  - **IDLE**
    - Ignore `writer_done` and `vs_edge`.
    - Hold `w_idx` = 0, `r_idx` = 2, `ready_valid` = 0, `r_valid` = 0.
    - Go to PRIME when `enable` = 1.
  - **PRIME**
    - On `writer_done`: `ready_idx` ← `w_idx`, `ready_valid` ← 1, `w_idx` ← 3 − `w_idx` − `r_idx`, go to RUN.
    - `vs_edge` in PRIME: no action, `repeat_cnt` is not incremented.
  - **RUN**
    - `writer_done` only:
      - If `ready_valid` = 1, increment `drop_cnt`.
      - `ready_idx` ← `w_idx`, `ready_valid` ← 1, `w_idx` ← 3 − `w_idx` − `r_idx`.
    - `vs_edge` only:
      - If `ready_valid` = 1: `r_idx` ← `ready_idx`, `ready_valid` ← 0, `r_valid` ← 1.
      - Otherwise increment `repeat_cnt`; `r_idx` is unchanged.
    - Both in the same cycle:
      - `r_idx` ← old `w_idx`, `w_idx` ← 3 − old `w_idx` − old `r_idx`, `ready_valid` ← 0, `r_valid` ← 1.
      - Increment `drop_cnt` if old `ready_valid` = 1.
  - From PRIME or RUN, `enable` = 0 returns to IDLE next cycle. Indices, `ready_valid` and `r_valid` take their IDLE values. Counters hold.
- Watchdog:
  - Timer counts in PRIME/RUN, clears on `writer_done`, and saturates at `TIMEOUT_CYCLES`.
  - `stall` ← 1 when the timer reaches `TIMEOUT_CYCLES`.
  - `stall` clears on the next `writer_done` or on entering IDLE.

## Timing
- Reset (`sys_rst_n` = 0, asynchronous):
  - `state` = IDLE, `w_idx` = 0, `r_idx` = 2, `ready_valid` = 0.
  - `w_base_addr` = `BASE_ADDR`, `r_base_addr` = `BASE_ADDR` + 2·`FRAME_STRIDE`.
  - `r_valid` = 0, `drop_cnt` = 0, `repeat_cnt` = 0, `stall` = 0, `vs_prev` = 0, timer = 0.
- Latency:
  - An event sampled at edge N is visible on all outputs after edge N+1, i.e. one register stage.
  - `vs_edge` is qualified in the first cycle `vsync_sync2` is high, so a swap is visible 1 cycle after the vsync rises in this domain.
- The writer latches `w_base_addr` at its own frame start. The address changes only in the cycle after `writer_done`.
- Reset asserted mid-frame: all state returns to reset values immediately. No partial swap survives.
- Counters wrap at 2^CNT_W with no saturation.

## Test plan
- Reset, then `enable` = 1, one `writer_done`, one vsync rise. Required: `state` 0→1→2; `w_idx` 0→1; after vsync `r_idx` = 0, `r_base_addr` = 32'h0100_0000, `r_valid` = 1.
- Steady state, writer at 2× the vsync rate, 10 vsyncs. Required: `drop_cnt` = 10; `r_idx` ≠ `w_idx` every cycle; `r_base_addr` is always 0x0100_0000, 0x0110_0000 or 0x0120_0000.
- Writer stopped with vsync continuing, 5 vsyncs after one swap. Required: `repeat_cnt` = 5, `r_idx` unchanged; `stall` = 1 at `TIMEOUT_CYCLES` (use a small parameter, e.g. 100), and it clears on the next `writer_done`.
- `writer_done` and `vs_edge` in the same cycle, with `w_idx` = 1, `r_idx` = 0, `ready_valid` = 1. Required: next cycle `r_idx` = 1, `w_idx` = 2, `ready_valid` = 0, `drop_cnt` += 1.
- Hold `vsync_sync2` high for 4 cycles. Required: exactly one swap or repeat.
- `sys_rst_n` pulsed low mid-RUN for less than 1 clock. Required: outputs asynchronously return to reset values (`w_idx` = 0, `r_idx` = 2, counters = 0).
- `enable` dropped mid-RUN. Required: IDLE next cycle, counters hold.
